// File: rtl/decode_issue.sv
// Single-issue decode stage: RV32 subset decode, register-pending scoreboard,
// and a one-entry execute payload register with valid/ready handshake.
module decode_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [DATA_WIDTH-1:0]    if_instr,
    input  logic [DATA_WIDTH-1:0]    if_pc,
    output logic                     if_ready,
    input  logic                     wb_valid,
    input  logic [ADDRESS_WIDTH-1:0] wb_rd,
    output logic [ADDRESS_WIDTH-1:0] AD1,
    output logic [ADDRESS_WIDTH-1:0] AD2,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [ADDRESS_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [2:0]               ex_alu_op,
    output logic                     ex_alusrc,
    output logic                     ex_regwrite,
    output logic                     ex_memread,
    output logic                     ex_memwrite,
    output logic                     ex_branch,
    output logic                     ex_illegal
);
    localparam int NUM_REGS = 1 << ADDRESS_WIDTH;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_IMM = 3'd5;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    imm;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [2:0]               alu_op;
        logic                     alusrc;
        logic                     regwrite;
        logic                     memread;
        logic                     memwrite;
        logic                     branch;
        logic                     illegal;
    } ctrl_t;

    ctrl_t                    dec, ex_q;
    logic [6:0]               opcode;
    logic [ADDRESS_WIDTH-1:0] rs1, rs2;
    logic [2:0]               funct_op;
    logic                     funct_ok;
    logic                     use_rs1, use_rs2;
    logic                     hazard, issue;
    logic [31:0]              imm32;
    logic [NUM_REGS-1:0]      pend, pend_next;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[15 +: ADDRESS_WIDTH];
    assign rs2    = if_instr[20 +: ADDRESS_WIDTH];
    assign AD1    = rs1;
    assign AD2    = rs2;

    // R and I share the funct3 map; only R with funct7[5] turns add into sub.
    always_comb begin
        funct_ok = 1'b1;
        case (if_instr[14:12])
            3'b000:  funct_op = (opcode == OP_R && if_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b111:  funct_op = ALU_AND;
            3'b110:  funct_op = ALU_OR;
            3'b010:  funct_op = ALU_SLT;
            default: begin
                funct_op = ALU_ADD;
                funct_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        dec     = '0;
        dec.rd  = if_instr[11:7];
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                dec.alu_op   = funct_op;
                dec.regwrite = 1'b1;
                dec.illegal  = !funct_ok;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_I: begin
                imm32        = {{20{if_instr[31]}}, if_instr[31:20]};
                dec.alu_op   = funct_op;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.illegal  = !funct_ok;
                use_rs1      = 1'b1;
            end
            OP_LW: begin
                imm32        = {{20{if_instr[31]}}, if_instr[31:20]};
                dec.alu_op   = ALU_ADD;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                use_rs1      = 1'b1;
            end
            OP_SW: begin
                imm32        = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                dec.alu_op   = ALU_ADD;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_BR: begin
                imm32      = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                              if_instr[30:25], if_instr[11:8], 1'b0};
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_LUI: begin
                imm32        = {if_instr[31:12], 12'b0};
                dec.alu_op   = ALU_IMM;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_JAL: begin
                imm32        = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                                if_instr[20], if_instr[30:21], 1'b0};
                dec.alu_op   = ALU_IMM;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm = DATA_WIDTH'($signed(imm32));
        // Illegal words issue as inert bubbles: no register use, no side effects.
        if (dec.illegal) begin
            dec.imm      = '0;
            dec.alu_op   = ALU_ADD;
            dec.alusrc   = 1'b0;
            dec.regwrite = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.branch   = 1'b0;
            use_rs1      = 1'b0;
            use_rs2      = 1'b0;
        end
    end

    // Only the registered scoreboard is consulted, so writeback unblocks a cycle later.
    assign hazard = (use_rs1 && rs1 != '0 && pend[rs1]) ||
                    (use_rs2 && rs2 != '0 && pend[rs2]) ||
                    (dec.regwrite && dec.rd != '0 && pend[dec.rd]);
    assign if_ready = !hazard && (!ex_valid || ex_ready);
    assign issue    = if_valid && if_ready;

    always_comb begin
        pend_next = pend;
        if (wb_valid)
            pend_next[wb_rd] = 1'b0;
        if (issue && dec.regwrite && dec.rd != '0)
            pend_next[dec.rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_q     <= '0;
        end else begin
            pend <= pend_next;
            if (issue) begin
                ex_valid <= 1'b1;
                ex_pc    <= if_pc;
                ex_q     <= dec;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

    assign ex_rd       = ex_q.rd;
    assign ex_imm      = ex_q.imm;
    assign ex_alu_op   = ex_q.alu_op;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_branch   = ex_q.branch;
    assign ex_illegal  = ex_q.illegal;
endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: decode vector table, hazard/stall sequences, and a
// randomized run against a behavioural decode + scoreboard model.
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, wb_valid, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, ex_pc, ex_imm;
    logic [4:0]  wb_rd, AD1, AD2, ex_rd;
    logic [2:0]  ex_alu_op;
    logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;

    decode_issue #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .AD1(AD1), .AD2(AD2),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // fl = {alusrc, regwrite, memread, memwrite, branch, illegal}
    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  alu;
        logic [5:0]  fl;
    } pl_t;
    typedef struct packed {
        pl_t  p;
        logic u1;
        logic u2;
    } mdec_t;
    typedef struct {
        logic [31:0] instr;
        pl_t         pl;
    } vec_t;

    int checks = 0;
    int errors = 0;
    wire [45:0] act_pl = {ex_imm, ex_rd, ex_alu_op,
                          ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Decode from the ISA rules; immediates rebuilt with signed arithmetic.
    function automatic mdec_t ref_dec(input logic [31:0] w);
        mdec_t m;
        int x, a;
        logic [6:0] op;
        logic [2:0] f3;
        m = '0;
        x = w;
        op = w[6:0];
        f3 = w[14:12];
        m.p.rd = w[11:7];
        if (op == 7'h33 || op == 7'h13) begin
            if (f3 == 3'd0)      m.p.alu = (op == 7'h33 && w[30]) ? 3'd1 : 3'd0;
            else if (f3 == 3'd7) m.p.alu = 3'd2;
            else if (f3 == 3'd6) m.p.alu = 3'd3;
            else if (f3 == 3'd2) m.p.alu = 3'd4;
            else begin
                m.p.alu = 3'd0;
                m.p.fl  = 6'b000001;
                return m;
            end
            m.u1 = 1'b1;
            m.u2 = (op == 7'h33);
            if (op == 7'h13) begin
                a = x >>> 20;
                m.p.imm = a;
                m.p.fl  = 6'b110000;
            end else
                m.p.fl = 6'b010000;
        end else if (op == 7'h03) begin
            a = x >>> 20;
            m.p.imm = a;
            m.p.fl = 6'b111000;
            m.u1 = 1'b1;
        end else if (op == 7'h23) begin
            a = x >>> 25;
            m.p.imm = a * 32 + w[11:7];
            m.p.fl = 6'b100100;
            m.u1 = 1'b1;
            m.u2 = 1'b1;
        end else if (op == 7'h63) begin
            a = x >>> 31;
            m.p.imm = a * 4096 + w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2;
            m.p.alu = 3'd1;
            m.p.fl = 6'b000010;
            m.u1 = 1'b1;
            m.u2 = 1'b1;
        end else if (op == 7'h37) begin
            m.p.imm = w & 32'hFFFFF000;
            m.p.alu = 3'd5;
            m.p.fl = 6'b110000;
        end else if (op == 7'h6F) begin
            a = x >>> 31;
            m.p.imm = a * 1048576 + w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2;
            m.p.alu = 3'd5;
            m.p.fl = 6'b110000;
        end else
            m.p.fl = 6'b000001;
        return m;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        if_valid = 1'b0; ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        if_instr = '0; if_pc = '0;
        @(posedge clk); #1;
        chk("reset ex_valid", 64'(ex_valid), 64'd0);
        chk("reset payload", 64'({act_pl, ex_pc}), 64'd0);
        rst = 1'b0;
    endtask

    task automatic issue1(input logic [31:0] w);
        if_valid = 1'b1; ex_ready = 1'b1; if_instr = w;
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    vec_t vt[12];
    mdec_t d;
    logic [31:0] w;
    bit   m_pend[32];
    bit   mv, haz, rdy;
    pl_t  m_pl;
    logic [31:0] m_pc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'h00500093, {32'd5,          5'd1,  3'd0, 6'b110000}};
        vt[1]  = '{32'h402081B3, {32'd0,          5'd3,  3'd1, 6'b010000}};
        vt[2]  = '{32'h0020F233, {32'd0,          5'd4,  3'd2, 6'b010000}};
        vt[3]  = '{32'hFFC0A283, {32'hFFFFFFFC,   5'd5,  3'd0, 6'b111000}};
        vt[4]  = '{32'h0020A423, {32'd8,          5'd8,  3'd0, 6'b100100}};
        vt[5]  = '{32'hFE208CE3, {32'hFFFFFFF8,   5'd25, 3'd1, 6'b000010}};
        vt[6]  = '{32'h12345337, {32'h12345000,   5'd6,  3'd5, 6'b110000}};
        vt[7]  = '{32'h010000EF, {32'd16,         5'd1,  3'd5, 6'b110000}};
        vt[8]  = '{32'hFFFFFFFF, {32'd0,          5'd31, 3'd0, 6'b000001}};
        vt[9]  = '{32'h00109093, {32'd0,          5'd1,  3'd0, 6'b000001}};
        vt[10] = '{32'h0020E3B3, {32'd0,          5'd7,  3'd3, 6'b010000}};
        vt[11] = '{32'hFFF0A413, {32'hFFFFFFFF,   5'd8,  3'd4, 6'b110000}};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            if_valid = 1'b1; ex_ready = 1'b1; if_instr = vt[i].instr; if_pc = 32'h1000 + i * 4;
            @(negedge clk);
            chk($sformatf("vec%0d if_ready", i), 64'(if_ready), 64'd1);
            chk($sformatf("vec%0d AD1/AD2", i), 64'({AD1, AD2}),
                64'({vt[i].instr[19:15], vt[i].instr[24:20]}));
            @(posedge clk); #1;
            if_valid = 1'b0;
            chk($sformatf("vec%0d ex_valid", i), 64'(ex_valid), 64'd1);
            chk($sformatf("vec%0d payload", i), 64'(act_pl), 64'(vt[i].pl));
            chk($sformatf("vec%0d pc", i), 64'(ex_pc), 64'(32'h1000 + i * 4));
        end

        // RAW stall on x1 released one cycle after its writeback
        do_reset();
        issue1(32'h00500093);
        chk("addi x1 payload", 64'(act_pl), 64'(vt[0].pl));
        if_instr = 32'h00108133; if_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("raw stall", 64'(if_ready), 64'd0);
            @(posedge clk); #1;
        end
        wb_valid = 1'b1; wb_rd = 5'd1;
        @(negedge clk);
        chk("raw same-cycle wb", 64'(if_ready), 64'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("raw released", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;
        chk("add x2 issued", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd2}));

        // Backpressure: payload held while ex_ready=0
        do_reset();
        issue1(32'h00500093);
        ex_ready = 1'b0; if_instr = 32'h00100493; if_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp if_ready", 64'(if_ready), 64'd0);
            chk("bp hold", 64'({ex_valid, act_pl}), 64'({1'b1, vt[0].pl}));
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        chk("bp release", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;

        // Write to x0 never marks pending
        do_reset();
        issue1(32'h00100013);
        if_instr = 32'h00000133; if_valid = 1'b1;
        @(negedge clk);
        chk("x0 no stall", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;

        // x3 pending: writer blocked by WAW even with same-cycle wb, then re-set
        do_reset();
        issue1(32'h00100193);
        if_instr = 32'h00200193; if_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3;
        @(negedge clk);
        chk("waw same-cycle wb", 64'(if_ready), 64'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("waw released", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        if_instr = 32'h00018233;
        @(negedge clk);
        chk("x3 pending again", 64'(if_ready), 64'd0);
        @(posedge clk); #1;
        if_valid = 1'b0;

        // Illegal issues but leaves scoreboard clean
        do_reset();
        issue1(32'hFFFFFFFF);
        chk("illegal payload", 64'({ex_valid, ex_illegal, ex_regwrite, ex_memwrite}), 64'b1100);
        if_instr = 32'h000F82B3; if_valid = 1'b1;
        @(negedge clk);
        chk("illegal no pend", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;

        // Asynchronous reset mid-flight
        do_reset();
        issue1(32'h00500093);
        #2 rst = 1'b1;
        #1;
        chk("async rst clears", 64'({ex_valid, act_pl}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        if_instr = 32'h00108133; if_valid = 1'b1; ex_ready = 1'b1;
        @(negedge clk);
        chk("post-reset no hazard", 64'(if_ready), 64'd1);
        @(posedge clk); #1;

        // Randomized run against the model
        do_reset();
        mv = 1'b0; m_pl = '0; m_pc = '0;
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            w = $urandom;
            case ($urandom_range(0, 8))
                0: w[6:0] = 7'h33;
                1: w[6:0] = 7'h13;
                2: w[6:0] = 7'h03;
                3: w[6:0] = 7'h23;
                4: w[6:0] = 7'h63;
                5: w[6:0] = 7'h37;
                6: w[6:0] = 7'h6F;
                default: ;
            endcase
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            if_instr = w;
            if_pc    = $urandom;
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            wb_valid = 1'($urandom_range(0, 1));
            wb_rd    = 5'($urandom_range(0, 3));
            d = ref_dec(w);
            haz = (d.u1 && w[19:15] != 0 && m_pend[w[19:15]]) ||
                  (d.u2 && w[24:20] != 0 && m_pend[w[24:20]]) ||
                  (d.p.fl[4] && d.p.rd != 0 && m_pend[d.p.rd]);
            rdy = !haz && (!mv || ex_ready);
            @(negedge clk);
            chk("rand if_ready", 64'(if_ready), 64'(rdy));
            chk("rand AD", 64'({AD1, AD2}), 64'({w[19:15], w[24:20]}));
            chk("rand ex", 64'({ex_valid, act_pl}), 64'({mv, m_pl}));
            chk("rand pc", 64'(ex_pc), 64'(m_pc));
            if (wb_valid) m_pend[wb_rd] = 1'b0;
            if (if_valid && rdy) begin
                mv = 1'b1; m_pl = d.p; m_pc = if_pc;
                if (d.p.fl[4] && d.p.rd != 0) m_pend[d.p.rd] = 1'b1;
            end else if (ex_ready)
                mv = 1'b0;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
